// File: rtl/bnn_ctrl_regs_pkg.sv
// ---------------------------------------------------------------------------
// bnn_ctrl_regs_pkg
// Shared definitions for the BNN accelerator APB control register file:
//   - byte offsets of every register in the map
//   - VERSION read-back constant
//   - STATUS bit positions
//   - decoded register-select enum and the offset decoder
// ---------------------------------------------------------------------------
package bnn_ctrl_regs_pkg;

  localparam logic [7:0] OFF_WEIGHT     = 8'h00;
  localparam logic [7:0] OFF_LAST_ROW   = 8'h04;
  localparam logic [7:0] OFF_LAST_COL   = 8'h08;
  localparam logic [7:0] OFF_START      = 8'h0C;
  localparam logic [7:0] OFF_ACT_ADDR   = 8'h10;
  localparam logic [7:0] OFF_BATCH      = 8'h14;
  localparam logic [7:0] OFF_PSUM_ADDR  = 8'h18;
  localparam logic [7:0] OFF_ACCUMULATE = 8'h1C;
  localparam logic [7:0] OFF_STATUS     = 8'h20;
  localparam logic [7:0] OFF_IRQ_EN     = 8'h24;
  localparam logic [7:0] OFF_JOB_COUNT  = 8'h28;
  localparam logic [7:0] OFF_VERSION    = 8'h2C;

  localparam logic [31:0] VERSION_VALUE = 32'h0002_0000;

  localparam int unsigned STATUS_BUSY_BIT = 0;
  localparam int unsigned STATUS_DONE_BIT = 1;

  typedef enum logic [3:0] {
    SEL_WEIGHT,
    SEL_LAST_ROW,
    SEL_LAST_COL,
    SEL_START,
    SEL_ACT_ADDR,
    SEL_BATCH,
    SEL_PSUM_ADDR,
    SEL_ACCUMULATE,
    SEL_STATUS,
    SEL_IRQ_EN,
    SEL_JOB_COUNT,
    SEL_VERSION,
    SEL_NONE
  } reg_sel_e;

  // IRQ_EN only decodes when the interrupt feature is built in.
  function automatic reg_sel_e decode_offset(input logic [7:0] off,
                                             input logic       has_irq_en);
    reg_sel_e sel;
    sel = SEL_NONE;
    case (off)
      OFF_WEIGHT:     sel = SEL_WEIGHT;
      OFF_LAST_ROW:   sel = SEL_LAST_ROW;
      OFF_LAST_COL:   sel = SEL_LAST_COL;
      OFF_START:      sel = SEL_START;
      OFF_ACT_ADDR:   sel = SEL_ACT_ADDR;
      OFF_BATCH:      sel = SEL_BATCH;
      OFF_PSUM_ADDR:  sel = SEL_PSUM_ADDR;
      OFF_ACCUMULATE: sel = SEL_ACCUMULATE;
      OFF_STATUS:     sel = SEL_STATUS;
      OFF_IRQ_EN:     sel = has_irq_en ? SEL_IRQ_EN : SEL_NONE;
      OFF_JOB_COUNT:  sel = SEL_JOB_COUNT;
      OFF_VERSION:    sel = SEL_VERSION;
      default:        sel = SEL_NONE;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/bnn_ctrl_regs_job_tracker.sv
// ---------------------------------------------------------------------------
// bnn_job_tracker
// Job-tracking state for the BNN control register file.
//   i_clk, i_rst_n     clock, asynchronous active-low reset
//   i_start            accepted START command (only asserted while idle)
//   i_systolic_done    completion pulse from the systolic controller
//   i_clr_done         accepted write-1-to-clear of STATUS.done
//   i_irq_en           interrupt enable (tie low when no interrupt)
//   o_busy             job in flight
//   o_done             sticky job-complete flag
//   o_job_count        completed-job counter, wraps to 0
//   o_irq              registered done & enable
// ---------------------------------------------------------------------------
module bnn_job_tracker #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic             i_systolic_done,
  input  logic             i_clr_done,
  input  logic             i_irq_en,
  output logic             o_busy,
  output logic             o_done,
  output logic [CNT_W-1:0] o_job_count,
  output logic             o_irq
);

  logic             r_busy;
  logic             r_done;
  logic [CNT_W-1:0] r_job_count;
  logic             r_irq;
  logic             w_done_evt;

  // Completion only counts for a job actually in flight.
  assign w_done_evt = i_systolic_done & r_busy;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_job_count <= '0;
      r_irq       <= 1'b0;
    end else begin
      // START is rejected while busy, so start and completion never collide.
      if (w_done_evt) begin
        r_busy <= 1'b0;
      end else if (i_start) begin
        r_busy <= 1'b1;
      end

      // Set has priority over a simultaneous clear.
      if (w_done_evt) begin
        r_done <= 1'b1;
      end else if (i_clr_done) begin
        r_done <= 1'b0;
      end

      if (w_done_evt) begin
        r_job_count <= r_job_count + CNT_W'(1);
      end

      r_irq <= r_done & i_irq_en;
    end
  end

  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_job_count = r_job_count;
  assign o_irq       = r_irq;

endmodule

// File: rtl/bnn_ctrl_regs.sv
// ---------------------------------------------------------------------------
// bnn_ctrl_regs
// APB3 slave register file for the BNN systolic accelerator: configuration
// fields with read-back, one-cycle command pulses and job tracking.
//
// Optional feature macro: BNN_CTRL_REGS_IRQ_EN
//   defined   -> IRQ_EN register at 0x24, irq = registered done & IRQ_EN[0]
//   undefined -> irq tied low, 0x24 unmapped (pslverr)
//
// Ports:
//   clk, resetn                 clock, asynchronous active-low reset
//   s_apb_*                     APB3 slave (zero wait state, pready=1)
//   systolic_done               completion pulse from systolic controller
//   weight_transfer             one-cycle pulse, WEIGHT write bit0=1
//   systolic_start              one-cycle pulse, accepted START
//   last_row .. accumulate      configuration outputs
//   busy                        job in flight
//   irq                         level interrupt
// ---------------------------------------------------------------------------
module bnn_ctrl_regs
  import bnn_ctrl_regs_pkg::*;
#(
  parameter int unsigned ADDR_W      = 6,
  parameter int unsigned ROW_W       = 5,
  parameter int unsigned COL_W       = 5,
  parameter int unsigned ACT_ADDR_W  = 11,
  parameter int unsigned PSUM_ADDR_W = 11,
  parameter int unsigned BATCH_W     = 6,
  parameter int unsigned CNT_W       = 16
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic [31:0]            s_apb_paddr,
  input  logic                   s_apb_psel,
  input  logic                   s_apb_penable,
  input  logic                   s_apb_pwrite,
  input  logic [31:0]            s_apb_pwdata,
  output logic                   s_apb_pready,
  output logic [31:0]            s_apb_prdata,
  output logic                   s_apb_pslverr,
  input  logic                   systolic_done,
  output logic                   weight_transfer,
  output logic                   systolic_start,
  output logic [ROW_W-1:0]       last_row,
  output logic [COL_W-1:0]       last_col,
  output logic [ACT_ADDR_W-1:0]  activations_addr_start,
  output logic [PSUM_ADDR_W-1:0] partialsums_addr_start,
  output logic [BATCH_W-1:0]     batch,
  output logic                   accumulate,
  output logic                   busy,
  output logic                   irq
);

`ifdef BNN_CTRL_REGS_IRQ_EN
  localparam logic HAS_IRQ = 1'b1;
`else
  localparam logic HAS_IRQ = 1'b0;
`endif

  // Widen the decoded offset to at least 8 bits so it compares against the
  // package offsets; any decoded bit above bit 7 makes the access unmapped.
  localparam int unsigned OFF_W = (ADDR_W > 8) ? ADDR_W : 8;

  logic [OFF_W-1:0]       w_off_ext;
  logic                   w_off_hi;
  logic                   w_unaligned;
  reg_sel_e               w_sel;
  logic                   w_access;
  logic                   w_err;
  logic                   w_wr_ok;
  logic                   w_start_acc;
  logic                   w_clr_done;
  logic [31:0]            w_rdata;
  logic                   w_busy;
  logic                   w_done;
  logic [CNT_W-1:0]       w_job_count;
  logic                   w_irq;
  logic                   w_irq_en;
  logic                   w_unused_apb;

  logic                   r_weight_transfer;
  logic                   r_systolic_start;
  logic [ROW_W-1:0]       r_last_row;
  logic [COL_W-1:0]       r_last_col;
  logic [ACT_ADDR_W-1:0]  r_act_addr;
  logic [PSUM_ADDR_W-1:0] r_psum_addr;
  logic [BATCH_W-1:0]     r_batch;
  logic                   r_accumulate;

  assign w_off_ext   = OFF_W'(s_apb_paddr[ADDR_W-1:0]);
  assign w_off_hi    = |(w_off_ext >> 8);
  assign w_unaligned = |s_apb_paddr[1:0];
  assign w_sel       = (w_off_hi || w_unaligned) ? SEL_NONE
                                                 : decode_offset(w_off_ext[7:0], HAS_IRQ);
  assign w_access    = s_apb_psel & s_apb_penable;

  always_comb begin
    w_err = 1'b0;
    if (w_access) begin
      if (w_sel == SEL_NONE) begin
        w_err = 1'b1;
      end else if (s_apb_pwrite) begin
        if (w_sel == SEL_JOB_COUNT || w_sel == SEL_VERSION) begin
          w_err = 1'b1;
        end else if (w_busy && (w_sel inside {SEL_LAST_ROW, SEL_LAST_COL, SEL_START,
                                              SEL_ACT_ADDR, SEL_BATCH, SEL_PSUM_ADDR,
                                              SEL_ACCUMULATE})) begin
          // Configuration is frozen for the duration of a job.
          w_err = 1'b1;
        end
      end
    end
  end

  assign w_wr_ok     = w_access & s_apb_pwrite & ~w_err;
  assign w_start_acc = w_wr_ok & (w_sel == SEL_START) & s_apb_pwdata[0];
  assign w_clr_done  = w_wr_ok & (w_sel == SEL_STATUS) & s_apb_pwdata[STATUS_DONE_BIT];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_weight_transfer <= 1'b0;
      r_systolic_start  <= 1'b0;
      r_last_row        <= '0;
      r_last_col        <= '0;
      r_act_addr        <= '0;
      r_psum_addr       <= '0;
      r_batch           <= '0;
      r_accumulate      <= 1'b0;
    end else begin
      r_weight_transfer <= w_wr_ok & (w_sel == SEL_WEIGHT) & s_apb_pwdata[0];
      r_systolic_start  <= w_start_acc;
      if (w_wr_ok) begin
        case (w_sel)
          SEL_LAST_ROW:   r_last_row   <= s_apb_pwdata[ROW_W-1:0];
          SEL_LAST_COL:   r_last_col   <= s_apb_pwdata[COL_W-1:0];
          SEL_ACT_ADDR:   r_act_addr   <= s_apb_pwdata[ACT_ADDR_W-1:0];
          SEL_BATCH:      r_batch      <= s_apb_pwdata[BATCH_W-1:0];
          SEL_PSUM_ADDR:  r_psum_addr  <= s_apb_pwdata[PSUM_ADDR_W-1:0];
          SEL_ACCUMULATE: r_accumulate <= s_apb_pwdata[0];
          default: ;
        endcase
      end
    end
  end

`ifdef BNN_CTRL_REGS_IRQ_EN
  logic r_irq_en;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_irq_en <= 1'b0;
    end else if (w_wr_ok && w_sel == SEL_IRQ_EN) begin
      r_irq_en <= s_apb_pwdata[0];
    end
  end

  assign w_irq_en = r_irq_en;
`else
  assign w_irq_en = 1'b0;
`endif

  bnn_job_tracker #(
    .CNT_W (CNT_W)
  ) u_job_tracker (
    .i_clk           (clk),
    .i_rst_n         (resetn),
    .i_start         (w_start_acc),
    .i_systolic_done (systolic_done),
    .i_clr_done      (w_clr_done),
    .i_irq_en        (w_irq_en),
    .o_busy          (w_busy),
    .o_done          (w_done),
    .o_job_count     (w_job_count),
    .o_irq           (w_irq)
  );

  // Read data reflects the registers before any update at the coming edge.
  always_comb begin
    w_rdata = '0;
    if (w_access && !s_apb_pwrite && !w_err) begin
      case (w_sel)
        SEL_LAST_ROW:   w_rdata = 32'(r_last_row);
        SEL_LAST_COL:   w_rdata = 32'(r_last_col);
        SEL_ACT_ADDR:   w_rdata = 32'(r_act_addr);
        SEL_BATCH:      w_rdata = 32'(r_batch);
        SEL_PSUM_ADDR:  w_rdata = 32'(r_psum_addr);
        SEL_ACCUMULATE: w_rdata = 32'(r_accumulate);
        SEL_STATUS: begin
          w_rdata[STATUS_BUSY_BIT] = w_busy;
          w_rdata[STATUS_DONE_BIT] = w_done;
        end
        SEL_IRQ_EN:     w_rdata = 32'(w_irq_en);
        SEL_JOB_COUNT:  w_rdata = 32'(w_job_count);
        SEL_VERSION:    w_rdata = VERSION_VALUE;
        default: ;
      endcase
    end
  end

  assign w_unused_apb = ^{s_apb_paddr, s_apb_pwdata};

  assign s_apb_pready           = 1'b1;
  assign s_apb_prdata           = w_rdata;
  assign s_apb_pslverr          = w_err;
  assign weight_transfer        = r_weight_transfer;
  assign systolic_start         = r_systolic_start;
  assign last_row               = r_last_row;
  assign last_col               = r_last_col;
  assign activations_addr_start = r_act_addr;
  assign partialsums_addr_start = r_psum_addr;
  assign batch                  = r_batch;
  assign accumulate             = r_accumulate;
  assign busy                   = w_busy;
  assign irq                    = w_irq;

endmodule
